// File: rtl/pcie_msix_pkg.sv
// Shared encodings for the UltraScale+ external-table MSI-X controller.
//   - Table select codes used by the BAR register read/write ports.
//   - Delivery FSM state codes.
package pcie_msix_pkg;

  localparam logic [2:0] SEL_ADDR_LO = 3'd0;
  localparam logic [2:0] SEL_ADDR_HI = 3'd1;
  localparam logic [2:0] SEL_DATA    = 3'd2;
  localparam logic [2:0] SEL_CTRL    = 3'd3;
  localparam logic [2:0] SEL_PBA     = 3'd4;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LOOKUP = 2'd1;
  localparam logic [1:0] ST_ISSUE  = 2'd2;
  localparam logic [1:0] ST_WAIT   = 2'd3;

endpackage

// File: rtl/pcie_msix_prio_enc.sv
// Lowest-index priority encoder over a request vector.
//   req   : one bit per vector (pending and unmasked)
//   idx   : lowest set index of req (0 when none)
//   found : at least one bit of req is set
module pcie_msix_prio_enc #(
  parameter int N  = 32,
  parameter int IW = 5
) (
  input  logic [N-1:0]  req,
  output logic [IW-1:0] idx,
  output logic          found
);

  // Scanning downward lets the lowest set bit be the last assignment.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx   = IW'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pcie_us_msix_ctrl.sv
// External-table MSI-X controller for the UltraScale+ PCIe hard IP.
// Holds the MSI-X table (address/data/mask per vector) and the PBA, accepts
// interrupt requests by vector index and drives the cfg_interrupt_msix_*
// handshake with masking, pending, retry-on-fail and timeout.
// Ports:
//   clk, rst                    : user clock, asynchronous active-high reset
//   s_axis_irq_*                : interrupt request stream (vector index)
//   tbl_wr_*                    : table write port (sel 0..3)
//   tbl_rd_*                    : table/PBA read port, data one cycle later
//   cfg_interrupt_msix_*        : hard IP MSI-X interface
//   cfg_interrupt_msi_function_number : tied to 0
//   stat_irq_sent/fail/drop     : one-cycle event pulses
module pcie_us_msix_ctrl
  import pcie_msix_pkg::*;
#(
  parameter int IRQ_INDEX_WIDTH = 5,
  parameter int IRQ_COUNT       = 32,
  parameter int WAIT_TIMEOUT    = 1024
) (
  input  logic                       clk,
  input  logic                       rst,

  input  logic [IRQ_INDEX_WIDTH-1:0] s_axis_irq_index,
  input  logic                       s_axis_irq_valid,
  output logic                       s_axis_irq_ready,

  input  logic                       tbl_wr_en,
  input  logic [IRQ_INDEX_WIDTH-1:0] tbl_wr_addr,
  input  logic [1:0]                 tbl_wr_sel,
  input  logic [31:0]                tbl_wr_data,
  input  logic                       tbl_rd_en,
  input  logic [IRQ_INDEX_WIDTH-1:0] tbl_rd_addr,
  input  logic [2:0]                 tbl_rd_sel,
  output logic [31:0]                tbl_rd_data,
  output logic                       tbl_rd_valid,

  input  logic                       cfg_interrupt_msix_enable,
  input  logic                       cfg_interrupt_msix_mask,
  output logic [63:0]                cfg_interrupt_msix_address,
  output logic [31:0]                cfg_interrupt_msix_data,
  output logic                       cfg_interrupt_msix_int,
  output logic [1:0]                 cfg_interrupt_msix_vec_pending,
  input  logic                       cfg_interrupt_msix_sent,
  input  logic                       cfg_interrupt_msix_fail,
  output logic [7:0]                 cfg_interrupt_msi_function_number,

  output logic                       stat_irq_sent,
  output logic                       stat_irq_fail,
  output logic                       stat_irq_drop
);

  localparam int VW        = $clog2(IRQ_COUNT);
  localparam int PBA_WORDS = IRQ_COUNT / 32;
  localparam int CW        = $clog2(WAIT_TIMEOUT) + 1;
  localparam logic [CW-1:0] TMO_LAST = CW'(WAIT_TIMEOUT - 1);

  logic [31:0]          addr_lo_tbl [IRQ_COUNT];
  logic [31:0]          addr_hi_tbl [IRQ_COUNT];
  logic [31:0]          data_tbl    [IRQ_COUNT];
  logic [IRQ_COUNT-1:0] mask_tbl;
  logic [IRQ_COUNT-1:0] pba;

  logic [1:0]           state;
  logic [VW-1:0]        sel_idx;
  logic [CW-1:0]        tmo_cnt;
  logic [63:0]          msix_addr_r;
  logic [31:0]          msix_data_r;
  logic                 msix_int_r;

  logic [31:0]          rd_data_p1;
  logic                 vld_p1;
  logic [31:0]          rd_mux;

  logic [IRQ_COUNT-1:0] pend_req;
  logic [VW-1:0]        enc_idx;
  logic                 enc_found;

  logic                 deliv_en;
  logic                 pend_go;
  logic [31:0]          req_idx_ext;
  logic                 req_in_range;
  logic [VW-1:0]        req_vec;
  logic                 req_deliv;
  logic                 hs;
  logic                 wait_sent;
  logic                 wait_fail;

  logic [31:0]          wr_addr_ext;
  logic [VW-1:0]        wr_vec;
  logic [31:0]          rd_addr_ext;
  logic [VW-1:0]        rd_vec;

  assign pend_req = pba & ~mask_tbl;

  pcie_msix_prio_enc #(
    .N  (IRQ_COUNT),
    .IW (VW)
  ) u_prio_enc (
    .req   (pend_req),
    .idx   (enc_idx),
    .found (enc_found)
  );

  assign deliv_en     = cfg_interrupt_msix_enable & ~cfg_interrupt_msix_mask;
  assign pend_go      = deliv_en & enc_found;
  assign req_idx_ext  = 32'(s_axis_irq_index);
  assign req_in_range = req_idx_ext < 32'(IRQ_COUNT);
  assign req_vec      = s_axis_irq_index[VW-1:0];
  assign req_deliv    = deliv_en & ~mask_tbl[req_vec];

  // Pending work takes priority over new requests; ready is held low in
  // reset so every output reads 0 while rst is asserted.
  assign s_axis_irq_ready = ~rst & (state == ST_IDLE) & ~pend_go;
  assign hs               = s_axis_irq_valid & s_axis_irq_ready;

  // A simultaneous sent+fail is treated as a fail.
  assign wait_sent = (state == ST_WAIT) & cfg_interrupt_msix_sent & ~cfg_interrupt_msix_fail;
  assign wait_fail = (state == ST_WAIT) &
                     (cfg_interrupt_msix_fail |
                      (~cfg_interrupt_msix_sent & (tmo_cnt == TMO_LAST)));

  assign stat_irq_sent = wait_sent;
  assign stat_irq_fail = wait_fail;
  assign stat_irq_drop = hs & ~req_in_range;

  assign cfg_interrupt_msix_address        = msix_addr_r;
  assign cfg_interrupt_msix_data           = msix_data_r;
  assign cfg_interrupt_msix_int            = msix_int_r;
  assign cfg_interrupt_msix_vec_pending    = 2'b00;
  assign cfg_interrupt_msi_function_number = 8'h00;

  // Delivery FSM and PBA
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      sel_idx     <= '0;
      tmo_cnt     <= '0;
      msix_addr_r <= '0;
      msix_data_r <= '0;
      msix_int_r  <= 1'b0;
      pba         <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pend_go) begin
            sel_idx <= enc_idx;
            state   <= ST_LOOKUP;
          end else if (hs && req_in_range) begin
            if (req_deliv) begin
              sel_idx <= req_vec;
              state   <= ST_LOOKUP;
            end else begin
              pba[req_vec] <= 1'b1;
            end
          end
        end
        ST_LOOKUP: begin
          msix_addr_r <= {addr_hi_tbl[sel_idx], addr_lo_tbl[sel_idx]};
          msix_data_r <= data_tbl[sel_idx];
          msix_int_r  <= 1'b1;
          state       <= ST_ISSUE;
        end
        ST_ISSUE: begin
          msix_int_r <= 1'b0;
          tmo_cnt    <= '0;
          state      <= ST_WAIT;
        end
        default: begin
          tmo_cnt <= tmo_cnt + 1'b1;
          if (wait_fail) begin
            pba[sel_idx] <= 1'b1;
            state        <= ST_IDLE;
          end else if (wait_sent) begin
            pba[sel_idx] <= 1'b0;
            state        <= ST_IDLE;
          end
        end
      endcase
    end
  end

  // Table write port
  assign wr_addr_ext = 32'(tbl_wr_addr);
  assign wr_vec      = tbl_wr_addr[VW-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < IRQ_COUNT; i++) begin
        addr_lo_tbl[i] <= '0;
        addr_hi_tbl[i] <= '0;
        data_tbl[i]    <= '0;
      end
      mask_tbl <= '1;
    end else if (tbl_wr_en && (wr_addr_ext < 32'(IRQ_COUNT))) begin
      case ({1'b0, tbl_wr_sel})
        SEL_ADDR_LO: addr_lo_tbl[wr_vec] <= tbl_wr_data;
        SEL_ADDR_HI: addr_hi_tbl[wr_vec] <= tbl_wr_data;
        SEL_DATA:    data_tbl[wr_vec]    <= tbl_wr_data;
        default:     mask_tbl[wr_vec]    <= tbl_wr_data[0];
      endcase
    end
  end

  // Table read port: stage 0 select
  assign rd_addr_ext = 32'(tbl_rd_addr);
  assign rd_vec      = tbl_rd_addr[VW-1:0];

  always_comb begin
    rd_mux = '0;
    case (tbl_rd_sel)
      SEL_ADDR_LO: if (rd_addr_ext < 32'(IRQ_COUNT)) rd_mux = addr_lo_tbl[rd_vec];
      SEL_ADDR_HI: if (rd_addr_ext < 32'(IRQ_COUNT)) rd_mux = addr_hi_tbl[rd_vec];
      SEL_DATA:    if (rd_addr_ext < 32'(IRQ_COUNT)) rd_mux = data_tbl[rd_vec];
      SEL_CTRL:    if (rd_addr_ext < 32'(IRQ_COUNT)) rd_mux = {31'b0, mask_tbl[rd_vec]};
      SEL_PBA: begin
        for (int w = 0; w < PBA_WORDS; w++) begin
          if (rd_addr_ext == 32'(w)) rd_mux = pba[32*w +: 32];
        end
      end
      default: rd_mux = '0;
    endcase
  end

  // Stage 1 register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1     <= 1'b0;
      rd_data_p1 <= '0;
    end else begin
      vld_p1 <= tbl_rd_en;
      if (tbl_rd_en) rd_data_p1 <= rd_mux;
    end
  end

  assign tbl_rd_valid = vld_p1;
  assign tbl_rd_data  = rd_data_p1;

endmodule

// File: tb/tb_pcie_us_msix_ctrl.sv
// Directed bench for pcie_us_msix_ctrl (6-bit index, 32 vectors, 16-cycle timeout).
module tb_pcie_us_msix_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  s_axis_irq_index;
  logic        s_axis_irq_valid;
  logic        s_axis_irq_ready;
  logic        tbl_wr_en;
  logic [5:0]  tbl_wr_addr;
  logic [1:0]  tbl_wr_sel;
  logic [31:0] tbl_wr_data;
  logic        tbl_rd_en;
  logic [5:0]  tbl_rd_addr;
  logic [2:0]  tbl_rd_sel;
  logic [31:0] tbl_rd_data;
  logic        tbl_rd_valid;
  logic        msix_enable;
  logic        msix_fmask;
  logic [63:0] msix_address;
  logic [31:0] msix_data;
  logic        msix_int;
  logic [1:0]  msix_vec_pending;
  logic        msix_sent;
  logic        msix_fail;
  logic [7:0]  msi_fn;
  logic        stat_irq_sent;
  logic        stat_irq_fail;
  logic        stat_irq_drop;

  int total = 0;
  int bad   = 0;
  logic [31:0] rdv;

  pcie_us_msix_ctrl #(
    .IRQ_INDEX_WIDTH (6),
    .IRQ_COUNT       (32),
    .WAIT_TIMEOUT    (16)
  ) dut (
    .clk                               (clk),
    .rst                               (rst),
    .s_axis_irq_index                  (s_axis_irq_index),
    .s_axis_irq_valid                  (s_axis_irq_valid),
    .s_axis_irq_ready                  (s_axis_irq_ready),
    .tbl_wr_en                         (tbl_wr_en),
    .tbl_wr_addr                       (tbl_wr_addr),
    .tbl_wr_sel                        (tbl_wr_sel),
    .tbl_wr_data                       (tbl_wr_data),
    .tbl_rd_en                         (tbl_rd_en),
    .tbl_rd_addr                       (tbl_rd_addr),
    .tbl_rd_sel                        (tbl_rd_sel),
    .tbl_rd_data                       (tbl_rd_data),
    .tbl_rd_valid                      (tbl_rd_valid),
    .cfg_interrupt_msix_enable         (msix_enable),
    .cfg_interrupt_msix_mask           (msix_fmask),
    .cfg_interrupt_msix_address        (msix_address),
    .cfg_interrupt_msix_data           (msix_data),
    .cfg_interrupt_msix_int            (msix_int),
    .cfg_interrupt_msix_vec_pending    (msix_vec_pending),
    .cfg_interrupt_msix_sent           (msix_sent),
    .cfg_interrupt_msix_fail           (msix_fail),
    .cfg_interrupt_msi_function_number (msi_fn),
    .stat_irq_sent                     (stat_irq_sent),
    .stat_irq_fail                     (stat_irq_fail),
    .stat_irq_drop                     (stat_irq_drop)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [5:0] a, input logic [1:0] s, input logic [31:0] d);
    tbl_wr_en   = 1'b1;
    tbl_wr_addr = a;
    tbl_wr_sel  = s;
    tbl_wr_data = d;
    step();
    tbl_wr_en = 1'b0;
  endtask

  task automatic rd(input logic [5:0] a, input logic [2:0] s, output logic [31:0] d);
    tbl_rd_en   = 1'b1;
    tbl_rd_addr = a;
    tbl_rd_sel  = s;
    step();
    tbl_rd_en = 1'b0;
    chk("rd_valid", {63'b0, tbl_rd_valid}, 64'd1);
    d = tbl_rd_data;
  endtask

  task automatic req(input logic [5:0] idx);
    chk("req_ready", {63'b0, s_axis_irq_ready}, 64'd1);
    s_axis_irq_valid = 1'b1;
    s_axis_irq_index = idx;
    step();
    s_axis_irq_valid = 1'b0;
  endtask

  task automatic send_ok();
    msix_sent = 1'b1;
    #1;
    chk("sent_pulse", {63'b0, stat_irq_sent}, 64'd1);
    step();
    msix_sent = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    s_axis_irq_index = '0; s_axis_irq_valid = 1'b0;
    tbl_wr_en = 1'b0; tbl_wr_addr = '0; tbl_wr_sel = '0; tbl_wr_data = '0;
    tbl_rd_en = 1'b0; tbl_rd_addr = '0; tbl_rd_sel = '0;
    msix_enable = 1'b0; msix_fmask = 1'b0; msix_sent = 1'b0; msix_fail = 1'b0;
    step();
    step();
    chk("rst_ready", {63'b0, s_axis_irq_ready}, 64'd0);
    chk("rst_int",   {63'b0, msix_int}, 64'd0);
    chk("rst_addr",  msix_address, 64'd0);
    chk("rst_data",  {32'b0, msix_data}, 64'd0);
    chk("rst_rdval", {63'b0, tbl_rd_valid}, 64'd0);
    chk("rst_stat",  {61'b0, stat_irq_sent, stat_irq_fail, stat_irq_drop}, 64'd0);
    rst = 1'b0;
    step();
    rd(6'd3, 3'd3, rdv);  chk("rst_mask3", {32'b0, rdv}, 64'd1);
    rd(6'd0, 3'd4, rdv);  chk("rst_pba",   {32'b0, rdv}, 64'd0);
    chk("fn_tie",  {56'b0, msi_fn}, 64'd0);
    chk("vp_tie",  {62'b0, msix_vec_pending}, 64'd0);

    // Basic delivery on vector 3
    msix_enable = 1'b1;
    wr(6'd3, 2'd0, 32'hFEE0_0000);
    wr(6'd3, 2'd2, 32'h0000_0041);
    wr(6'd3, 2'd3, 32'h0000_0000);
    req(6'd3);
    chk("v3_lookup_int", {63'b0, msix_int}, 64'd0);
    step();
    chk("v3_issue_int", {63'b0, msix_int}, 64'd1);
    chk("v3_addr", msix_address, 64'h0000_0000_FEE0_0000);
    chk("v3_data", {32'b0, msix_data}, 64'h41);
    step();
    chk("v3_int_low", {63'b0, msix_int}, 64'd0);
    step(); step(); step(); step();
    send_ok();
    chk("v3_sent_end", {63'b0, stat_irq_sent}, 64'd0);
    chk("v3_idle_ready", {63'b0, s_axis_irq_ready}, 64'd1);
    rd(6'd0, 3'd4, rdv);  chk("v3_pba", {32'b0, rdv}, 64'd0);

    // Masked vector 7, coalesced, then unmasked
    wr(6'd7, 2'd0, 32'hFEE0_0010);
    wr(6'd7, 2'd2, 32'h0000_0077);
    req(6'd7);
    req(6'd7);
    chk("v7_no_int", {63'b0, msix_int}, 64'd0);
    rd(6'd0, 3'd4, rdv);  chk("v7_pba_set", {32'b0, rdv}, 64'h80);
    wr(6'd7, 2'd3, 32'h0000_0000);
    chk("v7_pend_prio", {63'b0, s_axis_irq_ready}, 64'd0);
    step();
    step();
    chk("v7_int", {63'b0, msix_int}, 64'd1);
    chk("v7_addr", msix_address, 64'h0000_0000_FEE0_0010);
    chk("v7_data", {32'b0, msix_data}, 64'h77);
    step();
    send_ok();
    for (int k = 0; k < 6; k++) begin
      chk("v7_single", {63'b0, msix_int}, 64'd0);
      step();
    end
    rd(6'd0, 3'd4, rdv);  chk("v7_pba_clr", {32'b0, rdv}, 64'd0);
    rd(6'd7, 3'd3, rdv);  chk("v7_mask_rd", {32'b0, rdv}, 64'd0);

    // Fail and retry on vector 2
    wr(6'd2, 2'd0, 32'hFEE0_0020);
    wr(6'd2, 2'd2, 32'h0000_0022);
    wr(6'd2, 2'd3, 32'h0000_0000);
    req(6'd2);
    step();
    chk("v2_int", {63'b0, msix_int}, 64'd1);
    step();
    msix_fail = 1'b1;
    #1;
    chk("v2_fail_pulse", {63'b0, stat_irq_fail}, 64'd1);
    step();
    msix_fail = 1'b0;
    chk("v2_retry_prio", {63'b0, s_axis_irq_ready}, 64'd0);
    step();
    step();
    chk("v2_retry_int", {63'b0, msix_int}, 64'd1);
    chk("v2_retry_data", {32'b0, msix_data}, 64'h22);
    step();
    rd(6'd0, 3'd4, rdv);  chk("v2_pba_set", {32'b0, rdv}, 64'h4);
    send_ok();
    rd(6'd0, 3'd4, rdv);  chk("v2_pba_clr", {32'b0, rdv}, 64'd0);

    // Timeout on vector 4
    wr(6'd4, 2'd0, 32'hFEE0_0040);
    wr(6'd4, 2'd2, 32'h0000_0044);
    wr(6'd4, 2'd3, 32'h0000_0000);
    req(6'd4);
    step();
    chk("v4_int", {63'b0, msix_int}, 64'd1);
    for (int k = 1; k <= 15; k++) begin
      step();
      chk("v4_no_tmo", {63'b0, stat_irq_fail}, 64'd0);
    end
    step();
    chk("v4_tmo_fail", {63'b0, stat_irq_fail}, 64'd1);
    step();
    chk("v4_tmo_end", {63'b0, stat_irq_fail}, 64'd0);
    chk("v4_retry_prio", {63'b0, s_axis_irq_ready}, 64'd0);
    step();
    step();
    chk("v4_retry_int", {63'b0, msix_int}, 64'd1);
    chk("v4_retry_data", {32'b0, msix_data}, 64'h44);
    step();
    rd(6'd0, 3'd4, rdv);  chk("v4_pba_set", {32'b0, rdv}, 64'h10);
    send_ok();
    rd(6'd0, 3'd4, rdv);  chk("v4_pba_clr", {32'b0, rdv}, 64'd0);

    // Out-of-range request is dropped
    s_axis_irq_valid = 1'b1;
    s_axis_irq_index = 6'd40;
    #1;
    chk("drop_pulse", {63'b0, stat_irq_drop}, 64'd1);
    step();
    s_axis_irq_valid = 1'b0;
    #1;
    chk("drop_end", {63'b0, stat_irq_drop}, 64'd0);
    chk("drop_idle", {63'b0, s_axis_irq_ready}, 64'd1);
    chk("drop_no_int", {63'b0, msix_int}, 64'd0);
    rd(6'd0, 3'd4, rdv);  chk("drop_pba", {32'b0, rdv}, 64'd0);

    // Lowest pending index wins once enable returns
    wr(6'd5, 2'd2, 32'h0000_0055);
    wr(6'd5, 2'd3, 32'h0000_0000);
    wr(6'd9, 2'd2, 32'h0000_0099);
    wr(6'd9, 2'd3, 32'h0000_0000);
    msix_enable = 1'b0;
    req(6'd9);
    req(6'd5);
    rd(6'd0, 3'd4, rdv);  chk("prio_pba", {32'b0, rdv}, 64'h220);
    msix_enable = 1'b1;
    step();
    step();
    chk("prio_first_int", {63'b0, msix_int}, 64'd1);
    chk("prio_first_data", {32'b0, msix_data}, 64'h55);
    step();
    send_ok();
    step();
    step();
    chk("prio_second_int", {63'b0, msix_int}, 64'd1);
    chk("prio_second_data", {32'b0, msix_data}, 64'h99);
    step();
    send_ok();
    rd(6'd0, 3'd4, rdv);  chk("prio_pba_clr", {32'b0, rdv}, 64'd0);

    // Read/write collision and out-of-range reads
    tbl_wr_en = 1'b1; tbl_wr_addr = 6'd10; tbl_wr_sel = 2'd0; tbl_wr_data = 32'hABCD_0000;
    tbl_rd_en = 1'b1; tbl_rd_addr = 6'd10; tbl_rd_sel = 3'd0;
    step();
    tbl_wr_en = 1'b0; tbl_rd_en = 1'b0;
    chk("coll_old", {32'b0, tbl_rd_data}, 64'd0);
    rd(6'd10, 3'd0, rdv); chk("coll_new", {32'b0, rdv}, 64'hABCD_0000);
    wr(6'd8, 2'd0, 32'h1234_5678);
    rd(6'd40, 3'd0, rdv); chk("oor_vec", {32'b0, rdv}, 64'd0);
    rd(6'd8, 3'd0, rdv);  chk("vec8_rd", {32'b0, rdv}, 64'h1234_5678);

    // Reset during WAIT
    wr(6'd7, 2'd3, 32'h0000_0001);
    req(6'd7);
    rd(6'd1, 3'd4, rdv);  chk("oor_pba", {32'b0, rdv}, 64'd0);
    req(6'd3);
    step();
    chk("rw_int", {63'b0, msix_int}, 64'd1);
    step();
    rst = 1'b1;
    #1;
    chk("rw_addr", msix_address, 64'd0);
    chk("rw_data", {32'b0, msix_data}, 64'd0);
    chk("rw_ready", {63'b0, s_axis_irq_ready}, 64'd0);
    chk("rw_int0", {63'b0, msix_int}, 64'd0);
    step();
    rst = 1'b0;
    #1;
    chk("rw_idle", {63'b0, s_axis_irq_ready}, 64'd1);
    rd(6'd3, 3'd3, rdv);  chk("rw_mask3", {32'b0, rdv}, 64'd1);
    rd(6'd0, 3'd4, rdv);  chk("rw_pba", {32'b0, rdv}, 64'd0);
    rd(6'd3, 3'd0, rdv);  chk("rw_addr3", {32'b0, rdv}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
